// File: rtl/pcpi_vec_pkg.sv
// Shared constants, FSM state type and SEW helpers for the PCPI vector coprocessor.
package pcpi_vec_pkg;

  localparam logic [6:0] OP_V       = 7'b1010111;
  localparam logic [6:0] OP_LOADFP  = 7'b0000111;
  localparam logic [6:0] OP_STOREFP = 7'b0100111;

  localparam logic [5:0] FUNCT6_VDOT = 6'b111001;
  localparam logic [1:0] MOP_UNIT    = 2'b00;
  localparam logic [1:0] MOP_STRIDED = 2'b10;

  // vtype is the 11-bit zimm of vsetvli; only vsew is acted upon
  localparam int VTYPE_W        = 11;
  localparam int VTYPE_VSEW_LSB = 2;
  localparam int VTYPE_VSEW_MSB = 4;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CFG,
    ST_MEM,
    ST_ALU,
    ST_DONE
  } state_t;

  // Value mask for one element of the given SEW encoding (0:8, 1:16, else 32)
  function automatic logic [31:0] sew_mask(input logic [1:0] sew);
    case (sew)
      2'd0:    return 32'h0000_00FF;
      2'd1:    return 32'h0000_FFFF;
      default: return 32'hFFFF_FFFF;
    endcase
  endfunction

  // Byte-enable pattern for one element before the in-word shift
  function automatic logic [3:0] sew_strb(input logic [1:0] sew);
    case (sew)
      2'd0:    return 4'b0001;
      2'd1:    return 4'b0011;
      default: return 4'b1111;
    endcase
  endfunction

endpackage

// File: rtl/pcpi_vec_regfile.sv
// Vector register file with element-granular access: two read ports and one
// write port. The write port can accumulate into the existing element, which
// lets vdot read vd, vs1 and vs2 in the same cycle with only two read ports.
module pcpi_vec_regfile
  import pcpi_vec_pkg::*;
#(
  parameter int VLEN  = 128,
  parameter int NVREG = 32,
  parameter int IW    = 5
) (
  input  logic                     clk,
  input  logic [1:0]               sew,
  input  logic [$clog2(NVREG)-1:0] ra_reg,
  input  logic [IW-1:0]            ra_idx,
  output logic [31:0]              ra_data,
  input  logic [$clog2(NVREG)-1:0] rb_reg,
  input  logic [IW-1:0]            rb_idx,
  output logic [31:0]              rb_data,
  input  logic                     we,
  input  logic                     wacc,
  input  logic [$clog2(NVREG)-1:0] wreg,
  input  logic [IW-1:0]            widx,
  input  logic [31:0]              wdata
);

  localparam int OW = $clog2(VLEN) + 1;

  logic [VLEN-1:0] regs [NVREG];

  logic [OW-1:0]   off_a, off_b, off_w;
  logic [31:0]     old_w, new_w;
  logic [VLEN-1:0] wmask, wvec;

  // Element extraction and write-merge for the selected SEW
  always_comb begin
    off_a   = OW'(ra_idx) << (3 + sew);
    off_b   = OW'(rb_idx) << (3 + sew);
    off_w   = OW'(widx) << (3 + sew);
    ra_data = 32'(regs[ra_reg] >> off_a) & sew_mask(sew);
    rb_data = 32'(regs[rb_reg] >> off_b) & sew_mask(sew);
    old_w   = 32'(regs[wreg] >> off_w) & sew_mask(sew);
    new_w   = (wacc ? (old_w + wdata) : wdata) & sew_mask(sew);
    wmask   = VLEN'(sew_mask(sew)) << off_w;
    wvec    = VLEN'(new_w) << off_w;
  end

  // Contents are deliberately not reset; only the addressed element changes
  always_ff @(posedge clk) begin
    if (we) regs[wreg] <= (regs[wreg] & ~wmask) | wvec;
  end

endmodule

// File: rtl/pcpi_vec_coprocessor.sv
// PCPI vector coprocessor: vsetvli, unit/strided vector load/store over a
// private word-wide memory port, and element-wise vdot.vv multiply-accumulate.
//
// state   | meaning
// --------+-------------------------------------------------------------
// ST_IDLE | waiting for a decodable instruction (skips one cycle after DONE)
// ST_CFG  | vsetvli accepted, vl/vtype already updated
// ST_MEM  | one load/store element per memory transaction, ascending index
// ST_ALU  | one vdot element per cycle
// ST_DONE | pcpi_ready pulse (pcpi_wr for vsetvli)
module pcpi_vec_coprocessor
  import pcpi_vec_pkg::*;
#(
  parameter int VLEN  = 128,
  parameter int NVREG = 32
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        pcpi_valid,
  input  logic [31:0] pcpi_insn,
  input  logic [31:0] pcpi_cpurs1,
  input  logic [31:0] pcpi_cpurs2,
  output logic        pcpi_wr,
  output logic [31:0] pcpi_rd,
  output logic        pcpi_wait,
  output logic        pcpi_ready,
  output logic        mem_valid,
  input  logic        mem_ready,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_wstrb,
  input  logic [31:0] mem_rdata
);

  localparam int VLW = $clog2(VLEN / 8 + 1);
  localparam int RW  = $clog2(NVREG);

  state_t              state;
  logic [VTYPE_W-1:0]  vtype;
  logic [VLW-1:0]      vl;
  logic [VLW-1:0]      idx;
  logic [31:0]         ea;
  logic [31:0]         stride;
  logic [RW-1:0]       vd_q, vs1_q, vs2_q;
  logic                is_store;
  logic                skip;

  logic [6:0]          opcode;
  logic [2:0]          funct3;
  logic [1:0]          mop;
  logic                dec_vset, dec_vdot, dec_load, dec_store;
  logic [VTYPE_W-1:0]  zimm;
  logic [2:0]          new_vsew;
  logic [31:0]         vlmax, new_vl_full;
  logic [VLW-1:0]      new_vl;
  logic [1:0]          sew;
  logic [31:0]         unit_stride;

  logic [RW-1:0]       ra_reg;
  logic [31:0]         ra_data, rb_data;
  logic                rf_we, rf_wacc;
  logic [31:0]         rf_wdata;
  logic [31:0]         st_data;
  logic [3:0]          st_strb;
  logic [4:0]          byte_shift;

  logic                unused_vtype;
  assign unused_vtype = ^vtype;

  // Instruction decode and vsetvli length computation
  always_comb begin
    opcode      = pcpi_insn[6:0];
    funct3      = pcpi_insn[14:12];
    mop         = pcpi_insn[27:26];
    dec_vset    = (opcode == OP_V) && (funct3 == 3'b111) && !pcpi_insn[31];
    dec_vdot    = (opcode == OP_V) && (funct3 == 3'b000) &&
                  (pcpi_insn[31:26] == FUNCT6_VDOT);
    dec_load    = (opcode == OP_LOADFP) && ((mop == MOP_UNIT) || (mop == MOP_STRIDED));
    dec_store   = (opcode == OP_STOREFP) && ((mop == MOP_UNIT) || (mop == MOP_STRIDED));
    zimm        = pcpi_insn[30:20];
    new_vsew    = zimm[VTYPE_VSEW_MSB:VTYPE_VSEW_LSB];
    vlmax       = 32'(VLEN) >> (3 + new_vsew);
    if (new_vsew > 3'd2)
      new_vl_full = 32'd0;
    else if (pcpi_cpurs1 < vlmax)
      new_vl_full = pcpi_cpurs1;
    else
      new_vl_full = vlmax;
    new_vl      = VLW'(new_vl_full);
    sew         = vtype[VTYPE_VSEW_LSB +: 2];
    unit_stride = 32'd1 << sew;
  end

  // Regfile port steering and store/load lane alignment
  always_comb begin
    ra_reg     = (state == ST_MEM) ? vd_q : vs1_q;
    byte_shift = {ea[1:0], 3'b000};
    st_data    = ra_data << byte_shift;
    st_strb    = sew_strb(sew) << ea[1:0];
    rf_we      = 1'b0;
    rf_wacc    = 1'b0;
    rf_wdata   = mem_rdata >> byte_shift;
    if (state == ST_MEM) begin
      rf_we = mem_valid && mem_ready && !is_store;
    end else if (state == ST_ALU) begin
      rf_we    = (idx != vl);
      rf_wacc  = 1'b1;
      rf_wdata = ra_data * rb_data;
    end
  end

  pcpi_vec_regfile #(
    .VLEN  (VLEN),
    .NVREG (NVREG),
    .IW    (VLW)
  ) u_regfile (
    .clk     (clk),
    .sew     (sew),
    .ra_reg  (ra_reg),
    .ra_idx  (idx),
    .ra_data (ra_data),
    .rb_reg  (vs2_q),
    .rb_idx  (idx),
    .rb_data (rb_data),
    .we      (rf_we),
    .wacc    (rf_wacc),
    .wreg    (vd_q),
    .widx    (idx),
    .wdata   (rf_wdata)
  );

  // Control FSM with registered PCPI and memory outputs
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= ST_IDLE;
      vtype      <= '0;
      vl         <= '0;
      idx        <= '0;
      ea         <= '0;
      stride     <= '0;
      vd_q       <= '0;
      vs1_q      <= '0;
      vs2_q      <= '0;
      is_store   <= 1'b0;
      skip       <= 1'b0;
      pcpi_wr    <= 1'b0;
      pcpi_rd    <= '0;
      pcpi_wait  <= 1'b0;
      pcpi_ready <= 1'b0;
      mem_valid  <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      mem_wstrb  <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          pcpi_ready <= 1'b0;
          pcpi_wr    <= 1'b0;
          if (skip) begin
            // the CPU still holds pcpi_valid for the instruction just retired
            skip <= 1'b0;
          end else if (pcpi_valid && (dec_vset || dec_vdot || dec_load || dec_store)) begin
            pcpi_wait <= 1'b1;
            vd_q      <= pcpi_insn[11:7];
            vs1_q     <= pcpi_insn[19:15];
            vs2_q     <= pcpi_insn[24:20];
            is_store  <= dec_store;
            idx       <= '0;
            ea        <= pcpi_cpurs1;
            stride    <= (mop == MOP_STRIDED) ? pcpi_cpurs2 : unit_stride;
            pcpi_rd   <= dec_vset ? 32'(new_vl) : 32'd0;
            if (dec_vset) begin
              vtype <= zimm;
              vl    <= new_vl;
              state <= ST_CFG;
            end else if (dec_vdot) begin
              state <= ST_ALU;
            end else begin
              state <= ST_MEM;
            end
          end
        end
        ST_CFG: begin
          pcpi_wait  <= 1'b0;
          pcpi_ready <= 1'b1;
          pcpi_wr    <= 1'b1;
          state      <= ST_DONE;
        end
        ST_MEM: begin
          if (mem_valid) begin
            if (mem_ready) begin
              mem_valid <= 1'b0;
              mem_wstrb <= 4'b0000;
              idx       <= idx + 1'b1;
              ea        <= ea + stride;
            end
          end else if (idx == vl) begin
            pcpi_wait  <= 1'b0;
            pcpi_ready <= 1'b1;
            state      <= ST_DONE;
          end else begin
            mem_valid <= 1'b1;
            mem_addr  <= {ea[31:2], 2'b00};
            mem_wdata <= is_store ? st_data : 32'd0;
            mem_wstrb <= is_store ? st_strb : 4'b0000;
          end
        end
        ST_ALU: begin
          if (idx == vl) begin
            pcpi_wait  <= 1'b0;
            pcpi_ready <= 1'b1;
            state      <= ST_DONE;
          end else begin
            idx <= idx + 1'b1;
          end
        end
        ST_DONE: begin
          pcpi_ready <= 1'b0;
          pcpi_wr    <= 1'b0;
          skip       <= 1'b1;
          state      <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pcpi_vec_coprocessor.sv
// Directed bench for the PCPI vector coprocessor: configuration, strided and
// broadcast loads, 3x3 column-MAC matrix multiply, SEW8 wrap, vl=0, reset abort.
module tb_pcpi_vec_coprocessor;

  logic        clk;
  logic        reset;
  logic        pcpi_valid;
  logic [31:0] pcpi_insn;
  logic [31:0] pcpi_cpurs1;
  logic [31:0] pcpi_cpurs2;
  logic        pcpi_wr;
  logic [31:0] pcpi_rd;
  logic        pcpi_wait;
  logic        pcpi_ready;
  logic        mem_valid;
  logic        mem_ready;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wstrb;
  logic [31:0] mem_rdata;

  logic [31:0] mem [256];
  logic        mem_stall;
  int          xact;
  int          checks;
  int          failures;

  pcpi_vec_coprocessor dut (
    .clk         (clk),
    .reset       (reset),
    .pcpi_valid  (pcpi_valid),
    .pcpi_insn   (pcpi_insn),
    .pcpi_cpurs1 (pcpi_cpurs1),
    .pcpi_cpurs2 (pcpi_cpurs2),
    .pcpi_wr     (pcpi_wr),
    .pcpi_rd     (pcpi_rd),
    .pcpi_wait   (pcpi_wait),
    .pcpi_ready  (pcpi_ready),
    .mem_valid   (mem_valid),
    .mem_ready   (mem_ready),
    .mem_addr    (mem_addr),
    .mem_wdata   (mem_wdata),
    .mem_wstrb   (mem_wstrb),
    .mem_rdata   (mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory model: one-cycle response, byte-enabled writes, preload on reset
  always @(posedge clk) begin
    if (reset) begin
      mem_ready <= 1'b0;
      mem_rdata <= '0;
      for (int i = 0; i < 256; i++) mem[i] <= (i >= 120) ? 32'hA5A5_A5A5 : 32'h0;
      mem[100] <= 32'h0002_0001;
      mem[101] <= 32'h0004_0003;
      mem[102] <= 32'h0006_0005;
      mem[103] <= 32'h0008_0007;
      mem[104] <= 32'h000A_0009;
      mem[110] <= 32'h0028_000A;
      mem[111] <= 32'h0032_0014;
      mem[112] <= 32'h003C_001E;
      mem[113] <= 32'h0050_0046;
      mem[114] <= 32'h0000_005A;
      mem[115] <= 32'h0000_02C8;
    end else begin
      mem_ready <= 1'b0;
      if (mem_valid && !mem_ready && !mem_stall) begin
        mem_ready <= 1'b1;
        mem_rdata <= mem[mem_addr[9:2]];
        for (int b = 0; b < 4; b++)
          if (mem_wstrb[b]) mem[mem_addr[9:2]][8*b +: 8] <= mem_wdata[8*b +: 8];
        xact <= xact + 1;
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  // Present one instruction, wait (bounded) for ready, keep valid one cycle late
  task automatic issue(input string tag, input logic [31:0] insn, input logic [31:0] rs1,
                       input logic [31:0] rs2, output logic [31:0] rd, output logic wr);
    logic got;
    got = 1'b0;
    rd  = '0;
    wr  = 1'b0;
    @(negedge clk);
    pcpi_insn   = insn;
    pcpi_cpurs1 = rs1;
    pcpi_cpurs2 = rs2;
    pcpi_valid  = 1'b1;
    for (int c = 0; c < 300 && !got; c++) begin
      @(negedge clk);
      if (pcpi_ready) begin
        got = 1'b1;
        rd  = pcpi_rd;
        wr  = pcpi_wr;
      end
    end
    check({tag, "_ready"}, 32'(got), 32'd1);
    @(negedge clk);
    @(negedge clk);
    pcpi_valid = 1'b0;
  endtask

  function automatic logic [31:0] enc_vset(input logic [10:0] zimm);
    return {1'b0, zimm, 5'd10, 3'b111, 5'd11, 7'b1010111};
  endfunction

  function automatic logic [31:0] enc_vdot(input logic [4:0] vd, input logic [4:0] vs2,
                                           input logic [4:0] vs1);
    return {6'b111001, 1'b1, vs2, vs1, 3'b000, vd, 7'b1010111};
  endfunction

  function automatic logic [31:0] enc_mem(input logic store, input logic strided,
                                          input logic [4:0] vreg);
    return {3'b000, 1'b0, strided, 1'b0, 1'b1, 5'd12, 5'd10, 3'b101, vreg,
            store ? 7'b0100111 : 7'b0000111};
  endfunction

  initial begin
    logic [31:0] rd;
    logic        wr;
    int          x0;
    logic        seen;
    int          baddr [9];

    checks      = 0;
    failures    = 0;
    xact        = 0;
    mem_stall   = 1'b0;
    reset       = 1'b1;
    pcpi_valid  = 1'b0;
    pcpi_insn   = '0;
    pcpi_cpurs1 = '0;
    pcpi_cpurs2 = '0;
    repeat (4) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);

    check("rst_ready", 32'(pcpi_ready), 32'd0);
    check("rst_wait",  32'(pcpi_wait),  32'd0);
    check("rst_wr",    32'(pcpi_wr),    32'd0);
    check("rst_rd",    pcpi_rd,         32'd0);
    check("rst_mvalid", 32'(mem_valid), 32'd0);
    check("rst_wstrb", 32'(mem_wstrb),  32'd0);

    // vsetvli
    issue("vset3", enc_vset(11'h004), 32'd3, 32'd0, rd, wr);
    check("vset3_rd", rd, 32'd3);
    check("vset3_wr", 32'(wr), 32'd1);
    issue("vset100", enc_vset(11'h004), 32'd100, 32'd0, rd, wr);
    check("vset100_sew16", rd, 32'd8);
    issue("vset32", enc_vset(11'h008), 32'd100, 32'd0, rd, wr);
    check("vset100_sew32", rd, 32'd4);
    issue("vsetbad", enc_vset(11'h00C), 32'd5, 32'd0, rd, wr);
    check("vset_sew64_vl0", rd, 32'd0);
    issue("vset_l3", enc_vset(11'h004), 32'd3, 32'd0, rd, wr);
    check("vset_l3_rd", rd, 32'd3);

    // strided loads of the matrix columns
    x0 = xact;
    issue("ld_v1", enc_mem(1'b0, 1'b1, 5'd1), 32'd400, 32'd6, rd, wr);
    check("ld_v1_xacts", 32'(xact - x0), 32'd3);
    check("ld_v1_wr", 32'(wr), 32'd0);
    issue("ld_v2", enc_mem(1'b0, 1'b1, 5'd2), 32'd402, 32'd6, rd, wr);
    issue("ld_v3", enc_mem(1'b0, 1'b1, 5'd3), 32'd404, 32'd6, rd, wr);

    // broadcast B elements (column-major) into v11..v19, zero v8..v10
    baddr = '{440, 444, 448, 442, 446, 450, 452, 454, 456};
    for (int i = 0; i < 9; i++)
      issue("ld_bc", enc_mem(1'b0, 1'b1, 5'(11 + i)), 32'(baddr[i]), 32'd0, rd, wr);
    for (int i = 0; i < 3; i++)
      issue("ld_zero", enc_mem(1'b0, 1'b1, 5'(8 + i)), 32'd458, 32'd0, rd, wr);

    // unit-stride stores to inspect loaded registers
    issue("st_v1", enc_mem(1'b1, 1'b0, 5'd1), 32'd600, 32'd0, rd, wr);
    issue("st_v3", enc_mem(1'b1, 1'b0, 5'd3), 32'd608, 32'd0, rd, wr);
    issue("st_v11", enc_mem(1'b1, 1'b0, 5'd11), 32'd616, 32'd0, rd, wr);
    check("v1_lo", mem[150], 32'h0004_0001);
    check("v1_hi", mem[151], 32'hA5A5_0007);
    check("v3_lo", mem[152], 32'h0006_0003);
    check("v3_hi", mem[153], 32'hA5A5_0009);
    check("bc10_lo", mem[154], 32'h000A_000A);
    check("bc10_hi", mem[155], 32'hA5A5_000A);

    // column MAC matrix multiply, then strided column stores
    for (int j = 0; j < 3; j++)
      for (int k = 0; k < 3; k++)
        issue("vdot", enc_vdot(5'(8 + j), 5'(1 + k), 5'(11 + 3 * j + k)), 32'd0, 32'd0, rd, wr);
    for (int j = 0; j < 3; j++)
      issue("st_col", enc_mem(1'b1, 1'b1, 5'(8 + j)), 32'(500 + 2 * j), 32'd6, rd, wr);
    check("mm_w124", mem[124], 32'hA5A5_A5A5);
    check("mm_w125", mem[125], 32'h0140_008C);
    check("mm_w126", mem[126], 32'h0140_01F4);
    check("mm_w127", mem[127], 32'h04C4_0302);
    check("mm_w128", mem[128], 32'h04C4_01F4);
    check("mm_w129", mem[129], 32'hA5A5_0794);
    check("mm_w130", mem[130], 32'hA5A5_A5A5);

    // SEW8 wrap: 200*2 + 0 = 400 mod 256 = 0x90
    issue("vset8", enc_vset(11'h000), 32'd4, 32'd0, rd, wr);
    check("vset8_rd", rd, 32'd4);
    issue("ld_200", enc_mem(1'b0, 1'b1, 5'd20), 32'd460, 32'd0, rd, wr);
    issue("ld_2",   enc_mem(1'b0, 1'b1, 5'd21), 32'd461, 32'd0, rd, wr);
    issue("ld_0",   enc_mem(1'b0, 1'b1, 5'd22), 32'd462, 32'd0, rd, wr);
    issue("vdot8",  enc_vdot(5'd22, 5'd20, 5'd21), 32'd0, 32'd0, rd, wr);
    issue("st_v22", enc_mem(1'b1, 1'b0, 5'd22), 32'd640, 32'd0, rd, wr);
    check("sew8_wrap", mem[160], 32'h9090_9090);

    // vl = 0: completes with no memory traffic
    issue("vset0", enc_vset(11'h004), 32'd0, 32'd0, rd, wr);
    check("vset0_rd", rd, 32'd0);
    x0 = xact;
    issue("ld_vl0", enc_mem(1'b0, 1'b1, 5'd1), 32'd400, 32'd6, rd, wr);
    check("vl0_no_mem", 32'(xact - x0), 32'd0);

    // reset in the middle of a stalled load
    issue("vset_r", enc_vset(11'h004), 32'd3, 32'd0, rd, wr);
    mem_stall = 1'b1;
    @(negedge clk);
    pcpi_insn   = enc_mem(1'b0, 1'b1, 5'd5);
    pcpi_cpurs1 = 32'd400;
    pcpi_cpurs2 = 32'd6;
    pcpi_valid  = 1'b1;
    seen = 1'b0;
    for (int c = 0; c < 20 && !seen; c++) begin
      @(negedge clk);
      seen = mem_valid;
    end
    check("abort_mvalid_up", 32'(seen), 32'd1);
    check("abort_wait_up", 32'(pcpi_wait), 32'd1);
    #2 reset = 1'b1;
    #1;
    check("abort_mvalid", 32'(mem_valid), 32'd0);
    check("abort_wait", 32'(pcpi_wait), 32'd0);
    check("abort_ready", 32'(pcpi_ready), 32'd0);
    pcpi_valid = 1'b0;
    mem_stall  = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b0;

    // undecodable instruction is ignored
    @(negedge clk);
    pcpi_insn  = 32'h0000_0013;
    pcpi_valid = 1'b1;
    seen = 1'b0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      seen = seen | pcpi_wait | pcpi_ready;
    end
    check("undecoded_quiet", 32'(seen), 32'd0);
    pcpi_valid = 1'b0;
    @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
